// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: FSM states, CRC-32 constants and
// the forwarding delay-line beat.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        FRAME,
        DROP
    } rx_fcs_state_t;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    // The FCS is 4 bytes, so a 4-deep delay line hides exactly the FCS.
    localparam int          FWD_DEPTH     = 4;
    localparam int          LEN_WIDTH     = 11;

    typedef struct packed {
        logic       dv;
        logic [7:0] data;
        logic       tag;
        logic       keep;
    } fwd_beat_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32 (poly 0xEDB88320).
// No init or final inversion here; callers own those.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_comb begin
        logic [31:0] w_acc;
        // NOTE: blocking assignments on purpose; each bit step must see the
        // result of the previous one within the same evaluation.
        w_acc = i_crc ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC32_POLY) : (w_acc >> 1);
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive frame qualifier: checks preamble/SFD, CRC-32 and length,
// strips the FCS from the forwarded stream and counts good/bad frames.
module gmii_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_dv_i,
    input  logic                 rx_er_i,
    input  logic [7:0]           rx_d_i,
    output logic                 rx_dv_o,
    output logic [7:0]           rx_d_o,
    output logic                 frame_done_o,
    output logic                 fcs_ok_o,
    output logic                 len_err_o,
    output logic                 rx_err_o,
    output logic [10:0]          frame_len_o,
    output logic [CNT_WIDTH-1:0] good_cnt_o,
    output logic [CNT_WIDTH-1:0] bad_cnt_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_MIN = LEN_WIDTH'(MIN_FRAME_BYTES);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_FRAME_BYTES);
    localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;

    rx_fcs_state_t          r_state;
    logic                   r_dv_prev;
    logic                   r_tag;
    logic [31:0]            r_crc;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_err_acc;
    fwd_beat_t              r_dly [FWD_DEPTH];

    logic                   r_frame_done;
    logic                   r_fcs_ok;
    logic                   r_len_err;
    logic                   r_rx_err;
    logic [LEN_WIDTH-1:0]   r_frame_len;
    logic [CNT_WIDTH-1:0]   r_good_cnt;
    logic [CNT_WIDTH-1:0]   r_bad_cnt;

    logic [31:0]            w_crc_next;
    logic                   w_cur_tag;
    logic                   w_to_drop;
    logic                   w_keep;
    logic [LEN_WIDTH-1:0]   w_len_next;
    logic                   w_err_now;
    logic                   w_len_bad;
    logic                   w_fcs_good;

    crc32_d8 u_crc32_d8 (
        .i_crc  (r_crc),
        .i_data (rx_d_i),
        .o_crc  (w_crc_next)
    );

    // The tag flips in the very cycle dv rises, so a new frame immediately
    // masks the old frame's FCS still sitting in the delay line.
    assign w_cur_tag  = r_tag ^ (rx_dv_i & ~r_dv_prev);
    assign w_keep     = ~(w_to_drop | (r_state == DROP));
    assign w_len_next = (r_len == LEN_SAT) ? r_len : r_len + 1'b1;
    assign w_err_now  = r_err_acc | rx_er_i;
    assign w_len_bad  = (r_len < LEN_MIN) || (r_len > LEN_MAX);
    assign w_fcs_good = (r_crc == CRC32_RESIDUE);

    always_comb begin
        // NOTE: default assigned first so no case path can infer a latch.
        w_to_drop = 1'b0;
        case (r_state)
            IDLE:     w_to_drop = rx_dv_i & (r_dv_prev | (rx_d_i != ETH_PREAMBLE));
            PREAMBLE: w_to_drop = rx_dv_i & (rx_d_i != ETH_PREAMBLE) & (rx_d_i != ETH_SFD);
            default:  w_to_drop = 1'b0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            // Treat the line as busy after reset so a frame already in
            // flight is dropped rather than joined in the middle.
            r_dv_prev    <= 1'b1;
            r_tag        <= 1'b0;
            r_crc        <= CRC32_INIT;
            r_len        <= '0;
            r_err_acc    <= 1'b0;
            r_frame_done <= 1'b0;
            r_fcs_ok     <= 1'b0;
            r_len_err    <= 1'b0;
            r_rx_err     <= 1'b0;
            r_frame_len  <= '0;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
        end else begin
            r_dv_prev    <= rx_dv_i;
            r_tag        <= w_cur_tag;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_to_drop) begin
                        r_state <= DROP;
                    end else if (rx_dv_i) begin
                        r_state   <= PREAMBLE;
                        r_err_acc <= 1'b0;
                    end
                end
                PREAMBLE: begin
                    r_err_acc <= w_err_now;
                    if (!rx_dv_i) begin
                        r_state <= IDLE;
                    end else if (rx_d_i == ETH_SFD) begin
                        r_state <= FRAME;
                        r_crc   <= CRC32_INIT;
                        r_len   <= '0;
                    end else if (w_to_drop) begin
                        r_state <= DROP;
                    end
                end
                FRAME: begin
                    r_err_acc <= w_err_now;
                    if (rx_dv_i) begin
                        r_crc <= w_crc_next;
                        r_len <= w_len_next;
                    end else begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                        r_fcs_ok     <= w_fcs_good;
                        r_len_err    <= w_len_bad;
                        r_rx_err     <= w_err_now;
                        r_frame_len  <= r_len;
                        if (w_fcs_good && !w_len_bad && !w_err_now) begin
                            r_good_cnt <= r_good_cnt + 1'b1;
                        end else begin
                            r_bad_cnt  <= r_bad_cnt + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (!rx_dv_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            // NOTE: this small array is reset like ordinary flops; the
            // forwarding path must start empty after reset.
            for (int i = 0; i < FWD_DEPTH; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= '{dv: rx_dv_i, data: rx_d_i, tag: w_cur_tag, keep: w_keep};
            for (int i = 1; i < FWD_DEPTH; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign rx_dv_o = r_dly[FWD_DEPTH-1].dv & r_dly[FWD_DEPTH-1].keep & rx_dv_i &
                     (r_dly[FWD_DEPTH-1].tag == w_cur_tag);
    assign rx_d_o  = rx_dv_o ? r_dly[FWD_DEPTH-1].data : 8'h00;

    assign frame_done_o = r_frame_done;
    assign fcs_ok_o     = r_fcs_ok;
    assign len_err_o    = r_len_err;
    assign rx_err_o     = r_rx_err;
    assign frame_len_o  = r_frame_len;
    assign good_cnt_o   = r_good_cnt;
    assign bad_cnt_o    = r_bad_cnt;

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Scoreboard bench for gmii_rx_fcs_check: expected forwarded bytes and frame
// reports are queued with their due cycle when driven, and checked on output.
module tb_gmii_rx_fcs_check;

    localparam int CW = 16;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } fwd_exp_t;

    typedef struct {
        logic          fcs_ok;
        logic          len_err;
        logic          rx_err;
        logic [10:0]   len;
        logic [CW-1:0] good;
        logic [CW-1:0] bad;
        int            cyc;
    } rep_exp_t;

    logic          clk;
    logic          rstn_i;
    logic          rx_dv_i;
    logic          rx_er_i;
    logic [7:0]    rx_d_i;
    logic          rx_dv_o;
    logic [7:0]    rx_d_o;
    logic          frame_done_o;
    logic          fcs_ok_o;
    logic          len_err_o;
    logic          rx_err_o;
    logic [10:0]   frame_len_o;
    logic [CW-1:0] good_cnt_o;
    logic [CW-1:0] bad_cnt_o;

    gmii_rx_fcs_check #(
        .MIN_FRAME_BYTES (64),
        .MAX_FRAME_BYTES (1518),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .rx_dv_i      (rx_dv_i),
        .rx_er_i      (rx_er_i),
        .rx_d_i       (rx_d_i),
        .rx_dv_o      (rx_dv_o),
        .rx_d_o       (rx_d_o),
        .frame_done_o (frame_done_o),
        .fcs_ok_o     (fcs_ok_o),
        .len_err_o    (len_err_o),
        .rx_err_o     (rx_err_o),
        .frame_len_o  (frame_len_o),
        .good_cnt_o   (good_cnt_o),
        .bad_cnt_o    (bad_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fwd_exp_t      fwd_q[$];
    rep_exp_t      rep_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_good = '0;
    logic [CW-1:0] exp_bad  = '0;
    rep_exp_t      last_rep;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // 7x preamble, SFD, (flen-4) payload bytes, then FCS sent LSB first.
    function automatic byte_q_t build_frame(input int flen, input int seed);
        byte_q_t     q;
        logic [31:0] c;
        logic [7:0]  b;
        q = {};
        repeat (7) q.push_back(8'h55);
        q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < flen - 4; i++) begin
            b = 8'(seed * 31 + i * 7 + (i >> 3));
            q.push_back(b);
            c = crc_upd(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    // Output monitor: every cycle, away from the active edge.
    initial begin
        fwd_exp_t fe;
        rep_exp_t re;
        forever begin
            @(negedge clk);
            while (fwd_q.size() > 0 && fwd_q[0].cyc < cyc) begin
                fe = fwd_q.pop_front();
                n_vec++; n_err++;
                $display("FAIL fwd_missing: byte %02h due cycle %0d absent (now %0d)", fe.data, fe.cyc, cyc);
            end
            while (rep_q.size() > 0 && rep_q[0].cyc < cyc) begin
                re = rep_q.pop_front();
                n_vec++; n_err++;
                $display("FAIL report_missing: frame_done due cycle %0d absent (now %0d)", re.cyc, cyc);
            end
            if (rx_dv_o === 1'b1) begin
                n_vec++;
                if (fwd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fwd_unexpected: got byte %02h at cycle %0d, required none", rx_d_o, cyc);
                end else begin
                    fe = fwd_q.pop_front();
                    if (rx_d_o !== fe.data || cyc != fe.cyc) begin
                        n_err++;
                        $display("FAIL fwd_byte: got %02h at cycle %0d, required %02h at cycle %0d",
                                 rx_d_o, cyc, fe.data, fe.cyc);
                    end
                end
            end else begin
                n_vec++;
                if (rx_dv_o !== 1'b0 || rx_d_o !== 8'h00) begin
                    n_err++;
                    $display("FAIL fwd_idle: got dv=%b d=%02h at cycle %0d, required dv=0 d=00", rx_dv_o, rx_d_o, cyc);
                end
            end
            if (frame_done_o === 1'b1) begin
                n_vec++;
                if (rep_q.size() == 0) begin
                    n_err++;
                    $display("FAIL report_unexpected: frame_done at cycle %0d, required none", cyc);
                end else begin
                    re = rep_q.pop_front();
                    if ({fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o} !==
                        {re.fcs_ok, re.len_err, re.rx_err, re.len, re.good, re.bad} || cyc != re.cyc) begin
                        n_err++;
                        $display("FAIL report: got ok=%b lerr=%b rerr=%b len=%0d good=%0d bad=%0d @%0d, required ok=%b lerr=%b rerr=%b len=%0d good=%0d bad=%0d @%0d",
                                 fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o, cyc,
                                 re.fcs_ok, re.len_err, re.rx_err, re.len, re.good, re.bad, re.cyc);
                    end
                end
            end else if (frame_done_o !== 1'b0) begin
                n_vec++; n_err++;
                $display("FAIL frame_done_x: got %b at cycle %0d, required 0", frame_done_o, cyc);
            end
        end
    end

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_dv_i = dv;
        rx_er_i = er;
        rx_d_i  = d;
    endtask

    task automatic send_frame(input byte_q_t w, input int er_at, input int n_fwd,
                              input bit rep_en, input bit ok, input bit lerr,
                              input bit rerr, input int gap);
        rep_exp_t r;
        fwd_exp_t f;
        int       flen;
        for (int i = 0; i < w.size(); i++) begin
            drive(1'b1, (i == er_at), w[i]);
            if (i < n_fwd) begin
                f.data = w[i];
                f.cyc  = cyc + 4;
                fwd_q.push_back(f);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        if (rep_en) begin
            if (ok && !lerr && !rerr) exp_good++;
            else                      exp_bad++;
            flen      = w.size() - 8;
            r.fcs_ok  = ok;
            r.len_err = lerr;
            r.rx_err  = rerr;
            r.len     = (flen > 2047) ? 11'd2047 : 11'(flen);
            r.good    = exp_good;
            r.bad     = exp_bad;
            r.cyc     = cyc + 1;
            rep_q.push_back(r);
            last_rep  = r;
        end
        repeat (gap - 1) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; rx_dv_i = 1'b0; rx_er_i = 1'b0; rx_d_i = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({rx_dv_o, rx_d_o, frame_done_o, fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got dv=%b d=%02h done=%b ok=%b lerr=%b rerr=%b len=%0d good=%0d bad=%0d, required all 0",
                     rx_dv_o, rx_d_o, frame_done_o, fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o);
        end
        @(posedge clk);
        #1;
        rstn_i   = 1'b1;
        last_rep = '{default: 0};
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_good_frame();
        byte_q_t w;
        w = build_frame(64, 1);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    endtask

    task automatic test_bit_flip();
        byte_q_t w;
        w = build_frame(64, 1);
        w[18] = w[18] ^ 8'h04;
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    endtask

    task automatic test_length_bounds();
        byte_q_t w;
        w = build_frame(1519, 3);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b1, 1'b0, 6);
        w = build_frame(1518, 4);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        w = build_frame(63, 11);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b1, 1'b0, 6);
        // Three post-SFD bytes: no payload forwarded, only preamble.
        w = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hA1, 8'hB2, 8'hC3};
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b0, 1'b1, 1'b0, 6);
    endtask

    task automatic test_back_to_back();
        byte_q_t w;
        w = build_frame(64, 5);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        w = build_frame(70, 6);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    endtask

    task automatic test_preamble_error();
        byte_q_t w;
        w = build_frame(64, 7);
        w[3] = 8'h57;
        send_frame(w, -1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        @(negedge clk);
        n_vec++;
        if ({fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o} !==
            {last_rep.fcs_ok, last_rep.len_err, last_rep.rx_err, last_rep.len, last_rep.good, last_rep.bad}) begin
            n_err++;
            $display("FAIL drop_hold: got ok=%b lerr=%b rerr=%b len=%0d good=%0d bad=%0d, required ok=%b lerr=%b rerr=%b len=%0d good=%0d bad=%0d",
                     fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o,
                     last_rep.fcs_ok, last_rep.len_err, last_rep.rx_err, last_rep.len, last_rep.good, last_rep.bad);
        end
    endtask

    task automatic test_rx_error();
        byte_q_t w;
        w = build_frame(64, 8);
        send_frame(w, 28, w.size() - 4, 1'b1, 1'b1, 1'b0, 1'b1, 6);
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t  w;
        fwd_exp_t f;
        int       k;
        k = 20;
        w = build_frame(64, 9);
        for (int i = 0; i < w.size(); i++) begin
            @(posedge clk);
            #1;
            rstn_i  = (i != k);
            rx_dv_i = 1'b1;
            rx_er_i = 1'b0;
            rx_d_i  = w[i];
            if (i <= k - 4) begin
                f.data = w[i];
                f.cyc  = cyc + 4;
                fwd_q.push_back(f);
            end
            if (i == k) begin
                exp_good = '0;
                exp_bad  = '0;
                last_rep = '{default: 0};
            end
            if (i == k + 1) begin
                @(negedge clk);
                n_vec++;
                if ({rx_dv_o, rx_d_o, frame_done_o, fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o} !== '0) begin
                    n_err++;
                    $display("FAIL midframe_reset: got dv=%b d=%02h done=%b ok=%b lerr=%b rerr=%b len=%0d good=%0d bad=%0d, required all 0",
                             rx_dv_o, rx_d_o, frame_done_o, fcs_ok_o, len_err_o, rx_err_o, frame_len_o, good_cnt_o, bad_cnt_o);
                end
            end
        end
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        w = build_frame(64, 10);
        send_frame(w, -1, w.size() - 4, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bit_flip();
        test_length_bounds();
        test_back_to_back();
        test_preamble_error();
        test_rx_error();
        test_reset_mid_frame();
        repeat (10) drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        n_vec++;
        if (fwd_q.size() != 0 || rep_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d bytes and %0d reports outstanding, required 0 and 0", fwd_q.size(), rep_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
